// File: rtl/fp_acc_if.sv
// Handshake bundle of fp_accumulator: command, element stream, adder start/done and result.
interface fp_acc_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_count;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             add_start;
  logic [63:0]      add_a;
  logic [63:0]      add_b;
  logic [63:0]      add_result;
  logic             add_done;
  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;

  modport slave (
    input  cmd_valid, cmd_count, in_valid, in_data, add_result, add_done, res_ready,
    output cmd_ready, in_ready, add_start, add_a, add_b, res_valid, res_data
  );

  modport master (
    output cmd_valid, cmd_count, in_valid, in_data, add_result, add_done, res_ready,
    input  cmd_ready, in_ready, add_start, add_a, add_b, res_valid, res_data
  );
endinterface

// File: rtl/fp_accumulator.sv
// Sums N doubles strictly in input order ((x0+x1)+x2)... by driving an external fp_adder
// one addition at a time; the final sum is held on a valid/ready result port.
module fp_accumulator #(
  parameter int CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  fp_acc_if.slave bus,
  output logic    busy
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_FETCH  = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_RESULT = 3'd5
  } state_t;

  state_t           r_state;
  logic [63:0]      r_acc;
  logic [63:0]      r_op;
  logic [CNT_W-1:0] r_rem;
  logic             w_rem_last;

  assign w_rem_last = (r_rem == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_op    <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_rem <= bus.cmd_count;
            if (bus.cmd_count == '0) begin
              r_acc   <= '0;
              r_state <= S_RESULT;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        // First element seeds the accumulator directly; no adder pass is spent on it.
        S_LOAD: begin
          if (bus.in_valid) begin
            r_acc   <= bus.in_data;
            r_rem   <= r_rem - CNT_W'(1);
            r_state <= w_rem_last ? S_RESULT : S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.in_valid) begin
            r_op    <= bus.in_data;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.add_done) begin
            r_acc   <= bus.add_result;
            r_rem   <= r_rem - CNT_W'(1);
            r_state <= w_rem_last ? S_RESULT : S_FETCH;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so none follows an input combinationally.
  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.in_ready  = (r_state == S_LOAD) || (r_state == S_FETCH);
  assign bus.add_start = (r_state == S_ISSUE);
  assign bus.res_valid = (r_state == S_RESULT);
  assign busy          = (r_state != S_IDLE);
  assign bus.add_a     = r_acc;
  assign bus.add_b     = r_op;
  assign bus.res_data  = r_acc;
endmodule
